// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU data port and dmem_responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels in front of a
// word RAM, with WAIT_CYCLES wait states. DMEM_ERR_CHECK_EN enables fault flagging.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  flag_q, flag_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic [31:0]           mem [DEPTH];

    logic [31:0]           offset_c;
    logic [DEPTH_LOG2-1:0] idx_c;
    logic                  flag_c;
    logic                  acc_we_c;
    logic                  acc_flag_c;
    logic [DEPTH_LOG2-1:0] acc_idx_c;
    logic [31:0]           acc_wdata_c;
    logic [3:0]            acc_be_c;
    logic                  mem_we_c;

    // Decode of the incoming request address.
    always_comb begin
        offset_c = bus.req_addr - BASE_ADDR;
        idx_c    = DEPTH_LOG2'(offset_c >> 2);
`ifdef DMEM_ERR_CHECK_EN
        flag_c   = (bus.req_addr[1:0] != 2'b00) ||
                   (33'(offset_c) >= (33'(4) << DEPTH_LOG2));
`else
        flag_c   = 1'b0;
`endif
    end

    // With zero wait states the commit edge is the accept edge, so use live inputs in IDLE.
    always_comb begin
        acc_we_c    = (state_q == ST_IDLE) ? bus.req_we    : we_q;
        acc_flag_c  = (state_q == ST_IDLE) ? flag_c        : flag_q;
        acc_idx_c   = (state_q == ST_IDLE) ? idx_c         : idx_q;
        acc_wdata_c = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
        acc_be_c    = (state_q == ST_IDLE) ? bus.req_be    : be_q;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        flag_d       = flag_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d    = bus.req_we;
                    flag_d  = flag_c;
                    idx_d   = idx_c;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_RESP && state_q != ST_RESP) begin
            mem_we_c     = rst && acc_we_c && !acc_flag_c;
            resp_rdata_d = (!acc_we_c && !acc_flag_c) ? mem[acc_idx_c] : 32'h0;
            resp_err_d   = acc_flag_c;
        end else if (state_d == ST_IDLE) begin
            resp_rdata_d = 32'h0;
            resp_err_d   = 1'b0;
        end

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            flag_q       <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            flag_q       <= flag_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // RAM is never reset; only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be_c[i]) mem[acc_idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus a randomized run
// against an array-based memory model. Honours DMEM_ERR_CHECK_EN.
module tb_dmem_responder;
    localparam int unsigned DEPTH_LOG2 = 10;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam int unsigned W          = 2;
    localparam logic [31:0] BASE       = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] model [DEPTH];

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WAIT_CYCLES(W),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic flagged(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
        logic [31:0] off;
        off = a - BASE;
        return (a % 4 != 0) || (off >= 32'(4 * DEPTH));
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    function automatic int unsigned word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off / 4) % DEPTH);
    endfunction

    task automatic send_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_be    = be;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(bus.req_ready), 32'd1);
        else tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 50) begin
            check("wait_req_ready", 32'(bus.req_ready), 32'd0);
            tick();
            lat++;
        end
        if (lat >= 50) check("resp_timeout", 32'(bus.resp_valid), 32'd1);
    endtask

    task automatic finish_resp(input int hold, input logic [31:0] er, input logic ee);
        check("resp_rdata", bus.resp_rdata, er);
        check("resp_err", 32'(bus.resp_err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_rdata", bus.resp_rdata, er);
            check("hold_err", 32'(bus.resp_err), 32'(ee));
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("done_valid", 32'(bus.resp_valid), 32'd0);
        check("done_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    // Full transaction with expectations taken from the memory model.
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int hold, input bit early,
                       output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic [31:0] mask;
        logic        exp_err;
        int unsigned w;
        int          lat;
        exp_err = flagged(a);
        w       = word_of(a);
        exp_rd  = (!we && !exp_err) ? model[w] : 32'h0;
        send_req(we, a, wd, be);
        if (early) bus.resp_ready = 1'b1;
        wait_resp(lat);
        check("latency", 32'(lat), 32'(W + 1));
        rd = bus.resp_rdata;
        finish_resp(early ? 0 : hold, exp_rd, exp_err);
        if (we && !exp_err) begin
            mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            model[w] = (model[w] & ~mask) | (wd & mask);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          lat;

        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_be     = 4'h0;
        bus.resp_ready = 1'b0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
            check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            check("rst_resp_rdata", bus.resp_rdata, 32'h0);
            check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        end
        rst = 1'b1;
        tick();
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Give the first 64 words defined contents.
        for (int i = 0; i < 64; i++)
            txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0, 1'b0, rd);

        // Store then load.
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd);
        check("store_rdata_zero", rd, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 1, 1'b0, rd);
        check("load_deadbeef", rd, 32'hDEAD_BEEF);

        // Byte lanes; load ignores byte enables.
        txn(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, 1'b0, rd);
        txn(1'b0, 32'h10, 32'h0, 4'b0010, 0, 1'b0, rd);
        check("byte_lane_merge", rd, 32'hDE22_BE44);

        // Store with no byte enables changes nothing.
        txn(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, rd);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, rd);
        check("be_zero_store", rd, 32'hDE22_BE44);

        // Backpressure with a second request waiting.
        send_req(1'b0, 32'h10, 32'h0, 4'hF);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h14;
        wait_resp(lat);
        check("bp_latency", 32'(lat), 32'(W + 1));
        finish_resp(5, 32'hDE22_BE44, 1'b0);
        txn(1'b0, 32'h14, 32'h0, 4'hF, 0, 1'b0, rd);
        check("bp_second_load", rd, model[5]);

        // Early resp_ready: transfer completes on the first response cycle.
        txn(1'b0, 32'h18, 32'h0, 4'hF, 0, 1'b1, rd);

        // Misaligned / out-of-range requests.
        txn(1'b0, 32'h12, 32'h0, 4'hF, 0, 1'b0, rd);
        txn(1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, 0, 1'b0, rd);
        txn(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, rd);
        check("word0_after_1000", rd, model[0]);

        // Reset mid-operation abandons the pending store.
        txn(1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 0, 1'b0, rd);
        send_req(1'b1, 32'h20, 32'h1234_5678, 4'hF);
        rst = 1'b0;
        tick();
        check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_release_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < int'(W) + 2; i++) begin
            check("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
            tick();
        end
        txn(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, rd);
        check("midrst_prior_word", rd, 32'h0BAD_F00D);

        // Randomized traffic over defined words, with aliases and odd offsets.
        for (int i = 0; i < 60; i++) begin
            a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'(4096 * $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3) == 0, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
